muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and FSM state encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the {hi, lo} pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign sum     = {1'b0, hi} + {1'b0, m};
  assign shifted = {hi, lo[XLEN-1]};
  assign diff    = shifted - {1'b0, m};

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div) begin
      // Remainder stays below the divisor, so a clear borrow bit means the subtract fits.
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end else begin
      hi_nxt = {1'b0, hi[XLEN-1:1]};
      lo_nxt = {hi[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, valid/ready in and out, flushable.
//   state   | meaning
//   MD_IDLE | waiting for an operation, in_ready high
//   MD_BUSY | iterating one step per cycle on magnitudes
//   MD_DONE | result held until out_ready
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  md_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi, lo, m;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  logic            a_signed, b_signed, sa, sb, neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf;
  logic [XLEN-1:0] special;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_raw, div_fix, fin;

  assign a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;
  // Remainder follows the dividend sign; everything else follows the XOR of operand signs.
  assign neg_in   = (op == MD_REM) ? sa : (sa ^ sb);

  assign b_zero = (b == '0);
  assign ovf    = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1) &&
                  ((op == MD_DIV) || (op == MD_REM));

  always_comb begin
    special = '0;
    if (b_zero) special = op[1] ? a : '1;
    else if (ovf) special = op[1] ? '0 : a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (md_is_div(op_q)),
    .hi     (hi),
    .lo     (lo),
    .m      (m),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  assign prod     = {hi_nxt, lo_nxt};
  assign prod_fix = neg_q ? -prod : prod;
  assign div_raw  = op_q[1] ? hi_nxt : lo_nxt;
  assign div_fix  = neg_q ? -div_raw : div_raw;

  always_comb begin
    fin = prod_fix[2*XLEN-1:XLEN];
    if (md_is_div(op_q)) fin = div_fix;
    else if (op_q == MD_MUL) fin = prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      m         <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= MD_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            neg_q    <= neg_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (md_is_div(op) && (b_zero || ovf)) begin
              result    <= special;
              out_valid <= 1'b1;
              state     <= MD_DONE;
            end else begin
              hi    <= '0;
              lo    <= md_is_div(op) ? mag_a : mag_b;
              m     <= md_is_div(op) ? mag_b : mag_a;
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            result    <= fin;
            out_valid <= 1'b1;
            state     <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= MD_IDLE;
          end
        end
        default: begin
          state     <= MD_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 with hand-computed results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op at the negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_take", {31'b0, in_ready}, 32'd1);
    check("out_valid_after_take", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int n;
    issue(o, x, y);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check(tag, result, exp);
    consume();
  endtask

  initial begin
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL with backpressure: result must hold and in_ready stay low.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    check("accept_busy", {31'b0, busy}, 32'd1);
    check("accept_in_ready", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    check("mul_lat", 32'(lat), 32'd32);
    check("mul", result, 32'hFFFF_FFEB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'hFFFF_FFEB);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    consume();

    // Back-to-back issue right after the handshake.
    issue(3'b101, 32'd100, 32'd7);
    check("b2b_accepted", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    check("divu_lat", 32'(lat), 32'd32);
    check("divu", result, 32'd14);
    consume();

    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         32);
    run_op("div_pos_neg", 3'b100, 32'd20,   32'hFFFF_FFFA, 32'hFFFF_FFFD, 32);
    run_op("rem_pos_neg", 3'b110, 32'd20,   32'hFFFF_FFFA, 32'd2,         32);

    // Special divides complete on the accept edge itself.
    run_op("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem_by0",    3'b110, 32'd5,         32'd0,         32'd5,         0);
    run_op("div_by0",    3'b100, 32'd9,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // Flush during step 10 with a competing in_valid.
    issue(3'b000, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    op = 3'b000;
    a = 32'd5;
    b = 32'd5;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_out_valid", 32'(seen), 32'd0);
    check("flush_nothing_accepted", {31'b0, in_ready}, 32'd1);

    // Reset at step 20 discards the op immediately.
    issue(3'b000, 32'd11, 32'd13);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
